// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display sharing one BCD decoder.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int GUARD  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*DIGITS-1:0] load_data,
  output logic [3:0]          bcd_out,
  input  logic [6:0]          seg_in,
  output logic [6:0]          seg_out,
  output logic [DIGITS-1:0]   an_out,
  output logic                busy
);

  localparam int MAXDG = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW    = $clog2(MAXDG + 1);
  localparam int IW    = $clog2(DIGITS);

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_GUARD,
    S_SHOW
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                loaded_q, loaded_d;
  logic [3:0]          bcd_q, bcd_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                gate_q, gate_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                frame_end;
  logic [3:0]          next_digit;
  logic                lz_blank;

  assign accept = load_valid & ~pending_q;

  // Sequencing: OFF -> GUARD -> SHOW -> GUARD ..., enable low overrides everything.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + 1'b1;
    frame_end = 1'b0;

    if (!enable) begin
      state_d = S_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          cnt_d = '0;
          if (loaded_q) begin
            state_d = S_GUARD;
            idx_d   = '0;
          end
        end
        S_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end
        end
        S_SHOW: begin
          if (cnt_q == DIV_LAST) begin
            state_d = S_GUARD;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d     = '0;
              frame_end = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Data path: the active value only changes at a frame boundary or while dark.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    loaded_d  = loaded_q | accept;

    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      if (state_q == S_OFF || frame_end) begin
        active_d = load_data;
      end else begin
        shadow_d  = load_data;
        pending_d = 1'b1;
      end
    end
  end

  // Output values for the coming cycle, derived from the next state and next active value.
  always_comb begin
    next_digit = active_d[{idx_d, 2'b00} +: 4];

    lz_blank = 1'b0;
`ifdef SEG7_LZB_EN
    if (idx_d != '0) begin
      lz_blank = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (k >= int'(idx_d) && active_d[4*k +: 4] != 4'd0) lz_blank = 1'b0;
      end
    end
`endif

    bcd_d  = 4'd0;
    an_d   = '1;
    gate_d = 1'b0;
    busy_d = (state_d != S_OFF);

    if (state_d != S_OFF) bcd_d = next_digit;
    if (state_d == S_SHOW && !lz_blank) begin
      an_d[idx_d] = 1'b0;
      gate_d      = (next_digit <= 4'd9);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_OFF;
      idx_q     <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      loaded_q  <= 1'b0;
      bcd_q     <= 4'd0;
      an_q      <= '1;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      loaded_q  <= loaded_d;
      bcd_q     <= bcd_d;
      an_q      <= an_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
    end
  end

  assign load_ready = ~pending_q;
  assign bcd_out    = bcd_q;
  assign an_out     = an_q;
  assign busy       = busy_q;
  assign seg_out    = gate_q ? seg_in : 7'd0;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: time-based reference model plus directed literal checks.
// Honours SEG7_LZB_EN the same way the design does.
module tb_seg7_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int GUARD  = 2;
  localparam int SLOT   = DIV + GUARD;
  localparam int FRAME  = DIGITS * SLOT;
`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b0;
  logic                load_valid = 1'b0;
  logic [4*DIGITS-1:0] load_data = '0;
  logic [6:0]          seg_in = '0;
  logic                load_ready;
  logic [3:0]          bcd_out;
  logic [6:0]          seg_out;
  logic [DIGITS-1:0]   an_out;
  logic                busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .bcd_out    (bcd_out),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: scanning is a position within the frame, t in [0, FRAME).
  logic                m_scan;
  int                  m_t;
  logic [4*DIGITS-1:0] m_active, m_shadow;
  logic                m_pending, m_loaded;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_scan = 1'b0; m_t = 0; m_active = '0; m_shadow = '0;
      m_pending = 1'b0; m_loaded = 1'b0;
    end else begin
      bit acc, fe;
      acc = load_valid && !m_pending;
      fe  = m_scan && enable && (m_t == FRAME - 1);
      if (fe && m_pending) begin
        m_active = m_shadow; m_pending = 1'b0;
      end else if (acc) begin
        if (!m_scan || fe) m_active = load_data;
        else begin m_shadow = load_data; m_pending = 1'b1; end
      end
      if (!enable) begin
        m_scan = 1'b0; m_t = 0;
      end else if (!m_scan) begin
        if (m_loaded) begin m_scan = 1'b1; m_t = 0; end
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
      if (acc) m_loaded = 1'b1;
    end
  end

  // Compare every cycle, on the falling edge.
  always @(negedge clk) begin
    logic [DIGITS-1:0] e_an;
    logic [3:0]        e_bcd;
    logic              e_busy, e_gate;
    int                slot, off;
    e_an = '1; e_bcd = 4'd0; e_busy = 1'b0; e_gate = 1'b0;
    if (m_scan) begin
      slot   = m_t / SLOT;
      off    = m_t % SLOT;
      e_bcd  = m_active[4*slot +: 4];
      e_busy = 1'b1;
      if (off >= GUARD && !(LZB && slot != 0 && (m_active >> (4*slot)) == 0)) begin
        e_an[slot] = 1'b0;
        e_gate     = (e_bcd <= 4'd9);
      end
    end
    check("an_out", 32'(an_out), 32'(e_an));
    check("bcd_out", 32'(bcd_out), 32'(e_bcd));
    check("busy", 32'(busy), 32'(e_busy));
    check("load_ready", 32'(load_ready), 32'(!m_pending));
    check("seg_out", 32'(seg_out), e_gate ? 32'(seg_in) : 32'd0);
  end

  // The decoder stand-in: arbitrary segment patterns every cycle.
  always @(posedge clk) begin
    #2;
    seg_in = 7'($urandom_range(1, 127));
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, release, then load one value while dark; returns 2 units after load edge E0.
  task automatic fresh_load(input logic [4*DIGITS-1:0] d);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    enable = 1'b1;
    @(posedge clk); #2;
    load_valid = 1'b1;
    load_data  = d;
    @(posedge clk); #2;
    load_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset release with no load: display must stay dark.
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    enable = 1'b1;
    wait_edges(5);
    check("idle_no_load_busy", 32'(busy), 32'd0);
    check("idle_no_load_an", 32'(an_out), 32'hF);
    #1;

    // 1234 loaded while dark: literal slot pins.
    load_valid = 1'b1;
    load_data  = 16'h1234;
    @(posedge clk); #2;
    load_valid = 1'b0;
    wait_edges(3);
    check("d0_show_an", 32'(an_out), 32'b1110);
    check("d0_show_bcd", 32'(bcd_out), 32'd4);
    check("d0_show_seg", 32'(seg_out), 32'(seg_in));
    wait_edges(4);
    check("d1_guard_an", 32'(an_out), 32'b1111);
    check("d1_guard_bcd", 32'(bcd_out), 32'd3);
    check("d1_guard_seg", 32'(seg_out), 32'd0);
    wait_edges(2);
    check("d1_show_an", 32'(an_out), 32'b1101);
    wait_edges(6);
    check("d2_show_an", 32'(an_out), 32'b1011);
    check("d2_show_bcd", 32'(bcd_out), 32'd2);
    wait_edges(6);
    check("d3_show_an", 32'(an_out), 32'b0111);
    check("d3_show_bcd", 32'(bcd_out), 32'd1);
    #1;

    // Mid-frame load of 5678, then 9999 stalled until the wrap.
    @(posedge clk); #2;
    load_valid = 1'b1;
    load_data  = 16'h5678;
    wait_edges(1);
    check("pending_ready", 32'(load_ready), 32'd0);
    #1;
    load_data = 16'h9999;
    wait_edges(1);
    check("stalled_ready", 32'(load_ready), 32'd0);
    check("old_frame_bcd", 32'(bcd_out), 32'd1);
    wait_edges(1);
    check("wrap_ready", 32'(load_ready), 32'd1);
    check("wrap_bcd", 32'(bcd_out), 32'd8);
    wait_edges(1);
    check("second_accept_ready", 32'(load_ready), 32'd0);
    #1;
    load_valid = 1'b0;
    wait_edges(1);
    check("new_d0_an", 32'(an_out), 32'b1110);
    check("new_d0_bcd", 32'(bcd_out), 32'd8);
    wait_edges(22);
    check("next_wrap_bcd", 32'(bcd_out), 32'd9);
    check("next_wrap_ready", 32'(load_ready), 32'd1);

    // Asynchronous reset in the middle of a SHOW slot.
    wait_edges(2);
    check("pre_reset_an", 32'(an_out), 32'b1110);
    #2;
    rst = 1'b1;
    #1;
    check("rst_an", 32'(an_out), 32'hF);
    check("rst_seg", 32'(seg_out), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);

    // Non-decimal digit 2 is lit dark.
    fresh_load(16'h4C21);
    wait_edges(15);
    check("hex_d2_an", 32'(an_out), 32'b1011);
    check("hex_d2_bcd", 32'(bcd_out), 32'hC);
    check("hex_d2_seg", 32'(seg_out), 32'd0);

    // Enable dropped in SHOW, then restored.
    #1;
    enable = 1'b0;
    wait_edges(1);
    check("disable_an", 32'(an_out), 32'hF);
    check("disable_busy", 32'(busy), 32'd0);
    #1;
    enable = 1'b1;
    wait_edges(1);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_guard_an", 32'(an_out), 32'hF);
    check("restart_bcd", 32'(bcd_out), 32'd1);
    wait_edges(2);
    check("restart_d0_an", 32'(an_out), 32'b1110);
    #1;

    // Leading zeros.
    fresh_load(16'h0030);
    wait_edges(3);
    check("lz30_d0_an", 32'(an_out), 32'b1110);
    wait_edges(6);
    check("lz30_d1_an", 32'(an_out), 32'b1101);
    wait_edges(6);
    check("lz30_d2_an", 32'(an_out), LZB ? 32'b1111 : 32'b1011);
    check("lz30_d2_busy", 32'(busy), 32'd1);
    wait_edges(6);
    check("lz30_d3_an", 32'(an_out), LZB ? 32'b1111 : 32'b0111);
    #1;
    fresh_load(16'h0000);
    wait_edges(3);
    check("lz00_d0_an", 32'(an_out), 32'b1110);
    wait_edges(6);
    check("lz00_d1_an", 32'(an_out), LZB ? 32'b1111 : 32'b1101);
    #1;

    // Randomised traffic against the model.
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [4*DIGITS-1:0] d;
      for (int k = 0; k < DIGITS; k++)
        d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      enable     = ($urandom_range(0, 99) != 0);
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = d;
      @(posedge clk); #2;
    end
    load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #6;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
